// File: rtl/int_regfile_mp.sv
// Multi-ported integer register file: two write ports, two combinational
// read ports, optional hard-wired zero register and optional write-to-read
// forwarding. A small IDLE/CLEAR sequencer zeroes every register one per
// cycle after reset or on a soft-clear request, so no register relies on
// memory initialisation.
module int_regfile_mp #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int ZERO_X0 = 1,
    parameter int BYPASS  = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            we0,
    input  logic [AW-1:0]   waddr0,
    input  logic [XLEN-1:0] wdata0,
    input  logic            we1,
    input  logic [AW-1:0]   waddr1,
    input  logic [XLEN-1:0] wdata1,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            busy,
    output logic            o_dbg_state
);

    localparam bit           LP_ZERO = (ZERO_X0 != 0);
    localparam bit           LP_BYP  = (BYPASS != 0);
    localparam logic [AW-1:0] LP_LAST = AW'(NREG - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_nxt;
    logic            w_busy;
    logic            w_clr_wr;
    logic            w_wr_en0;
    logic            w_wr_en1;
    logic [XLEN-1:0] r_regs [NREG];
    logic [AW-1:0]   w_raddr [2];
    logic [XLEN-1:0] w_rdata [2];

    // Next-state and clear-counter logic for the zeroing sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (clr) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                // clr is deliberately not looked at here: a running
                // clear always finishes rather than restarting.
                if (r_cnt == LP_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + AW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State register; reset lands in CLEAR so every register gets zeroed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_busy      = (r_state == ST_CLEAR);
    assign busy        = w_busy;
    assign o_dbg_state = r_state;

    // A write is live only in IDLE, outside reset, when no clear starts at
    // this edge, and (with a hard-wired x0) when it does not target x0.
    // These same qualifiers gate forwarding, so a dropped write is never
    // visible on a read port.
    assign w_clr_wr = !rst && w_busy;
    assign w_wr_en0 = !rst && !w_busy && !clr && we0 &&
                      !(LP_ZERO && (waddr0 == '0));
    assign w_wr_en1 = !rst && !w_busy && !clr && we1 &&
                      !(LP_ZERO && (waddr1 == '0));

    // Register storage: clear sweep, else port 0 then port 1 so that
    // port 1 wins on a same-address collision.
    always_ff @(posedge clk) begin
        if (w_clr_wr) begin
            r_regs[r_cnt] <= '0;
        end else begin
            if (w_wr_en0) begin
                r_regs[waddr0] <= wdata0;
            end
            if (w_wr_en1) begin
                r_regs[waddr1] <= wdata1;
            end
        end
    end

    assign w_raddr[0] = raddr1;
    assign w_raddr[1] = raddr2;

    // Two identical, independent read ports.
    for (genvar p = 0; p < 2; p++) begin : g_rd
        // Read mux: zero while clearing or for x0, then forwarding, then storage.
        always_comb begin
            w_rdata[p] = r_regs[w_raddr[p]];
            if (w_busy) begin
                w_rdata[p] = '0;
            end else if (LP_ZERO && (w_raddr[p] == '0)) begin
                w_rdata[p] = '0;
            end else if (LP_BYP && w_wr_en1 && (waddr1 == w_raddr[p])) begin
                w_rdata[p] = wdata1;
            end else if (LP_BYP && w_wr_en0 && (waddr0 == w_raddr[p])) begin
                w_rdata[p] = wdata0;
            end
        end
    end

    assign rdata1 = w_rdata[0];
    assign rdata2 = w_rdata[1];

endmodule

// File: tb/tb_int_regfile_mp.sv
// Directed bench for int_regfile_mp: one instance with forwarding (BYPASS=1)
// and one without (BYPASS=0) share the same stimulus.
module tb_int_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        we0;
  logic [4:0]  waddr0;
  logic [31:0] wdata0;
  logic        we1;
  logic [4:0]  waddr1;
  logic [31:0] wdata1;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1, rdata2, nb_rdata1, nb_rdata2;
  logic        busy, nb_busy, dbg, nb_dbg;

  int n_cmp = 0;
  int n_err = 0;

  int_regfile_mp #(.XLEN(32), .NREG(32), .ZERO_X0(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .clr(clr),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .busy(busy), .o_dbg_state(dbg)
  );

  int_regfile_mp #(.XLEN(32), .NREG(32), .ZERO_X0(1), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .clr(clr),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(nb_rdata1), .rdata2(nb_rdata2),
    .busy(nb_busy), .o_dbg_state(nb_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 0; we0 = 0; we1 = 0;
    waddr0 = '0; wdata0 = '0; waddr1 = '0; wdata1 = '0;
  endtask

  // Counts edges until busy falls (bounded), checking reads stay 0.
  task automatic count_busy(input string tag, output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n_cmp++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || nb_rdata1 !== 32'h0) begin
        n_err++;
        $display("FAIL %s_rd_busy: cycle %0d got %h/%h/%h want 0", tag, n, rdata1, rdata2, nb_rdata1);
      end
      tick();
      n++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a);
      raddr2 = 5'(31 - a);
      #1;
      n_cmp++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || nb_rdata1 !== 32'h0 || nb_rdata2 !== 32'h0) begin
        n_err++;
        $display("FAIL %s_zero: addr %0d got %h/%h/%h/%h want 0", tag, a, rdata1, rdata2, nb_rdata1, nb_rdata2);
      end
    end
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    raddr1 = 5'd3; raddr2 = 5'd0;
    rst = 1;
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b1 || dbg !== 1'b1 || nb_busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_busy: got busy=%b dbg=%b nb=%b want 1", busy, dbg, nb_busy);
    end
    rst = 0;
    count_busy("reset", n);
    n_cmp++;
    if (n !== 32) begin
      n_err++;
      $display("FAIL reset_len: busy edges %0d want 32", n);
    end
    n_cmp++;
    if (busy !== 1'b0 || nb_busy !== 1'b0 || dbg !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done: got busy=%b nb=%b dbg=%b want 0", busy, nb_busy, dbg);
    end
    check_all_zero("reset");
  endtask

  task automatic test_write_read();
    we0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    raddr1 = 5'd5; raddr2 = 5'd6;
    #1;
    n_cmp++;
    if (rdata1 !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL wr_bypass: got %h want deadbeef", rdata1);
    end
    n_cmp++;
    if (nb_rdata1 !== 32'h0) begin
      n_err++;
      $display("FAIL wr_nobypass_same: got %h want 0", nb_rdata1);
    end
    tick();
    we0 = 0;
    #1;
    n_cmp++;
    if (rdata1 !== 32'hDEADBEEF || nb_rdata1 !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL wr_stored: got %h/%h want deadbeef", rdata1, nb_rdata1);
    end
  endtask

  task automatic test_conflict();
    we0 = 1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1; waddr1 = 5'd7; wdata1 = 32'h22;
    raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    n_cmp++;
    if (rdata1 !== 32'h22 || rdata2 !== 32'h22) begin
      n_err++;
      $display("FAIL conflict_bypass: got %h/%h want 22", rdata1, rdata2);
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (rdata1 !== 32'h22 || nb_rdata2 !== 32'h22) begin
      n_err++;
      $display("FAIL conflict_stored: got %h/%h want 22", rdata1, nb_rdata2);
    end
  endtask

  task automatic test_x0();
    we1 = 1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    raddr1 = 5'd5; raddr2 = 5'd0;
    #1;
    n_cmp++;
    if (rdata2 !== 32'h0 || nb_rdata2 !== 32'h0) begin
      n_err++;
      $display("FAIL x0_same: got %h/%h want 0", rdata2, nb_rdata2);
    end
    tick();
    we1 = 0;
    #1;
    n_cmp++;
    if (rdata2 !== 32'h0 || nb_rdata2 !== 32'h0) begin
      n_err++;
      $display("FAIL x0_after: got %h/%h want 0", rdata2, nb_rdata2);
    end
    n_cmp++;
    if (rdata1 !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL x0_neighbour: got %h want deadbeef", rdata1);
    end
  endtask

  task automatic test_dual_write();
    we0 = 1; waddr0 = 5'd3; wdata0 = 32'h33;
    we1 = 1; waddr1 = 5'd9; wdata1 = 32'h99;
    raddr1 = 5'd9; raddr2 = 5'd3;
    #1;
    n_cmp++;
    if (rdata1 !== 32'h99 || rdata2 !== 32'h33) begin
      n_err++;
      $display("FAIL dual_bypass: got %h/%h want 99/33", rdata1, rdata2);
    end
    tick();
    idle_inputs();
    raddr1 = 5'd3; raddr2 = 5'd3;
    #1;
    n_cmp++;
    if (nb_rdata1 !== 32'h33 || nb_rdata2 !== 32'h33) begin
      n_err++;
      $display("FAIL dual_dup_read: got %h/%h want 33/33", nb_rdata1, nb_rdata2);
    end
    raddr2 = 5'd9;
    #1;
    n_cmp++;
    if (nb_rdata2 !== 32'h99) begin
      n_err++;
      $display("FAIL dual_port1: got %h want 99", nb_rdata2);
    end
  endtask

  task automatic test_soft_clear();
    int n;
    for (int i = 1; i < 32; i++) begin
      we0 = 1; waddr0 = 5'(i); wdata0 = i;
      tick();
    end
    we0 = 0;
    raddr1 = 5'd17; raddr2 = 5'd31;
    #1;
    n_cmp++;
    if (nb_rdata1 !== 32'd17 || nb_rdata2 !== 32'd31) begin
      n_err++;
      $display("FAIL fill: got %h/%h want 11/1f", nb_rdata1, nb_rdata2);
    end
    // clear request with a write at the same edge: the write must drop
    clr = 1; we0 = 1; waddr0 = 5'd4; wdata0 = 32'hAAAA;
    tick();
    // hold clr (ignored) and keep both ports writing during the sweep
    waddr0 = 5'd2; wdata0 = 32'h5555;
    we1 = 1; waddr1 = 5'd30; wdata1 = 32'h3030;
    raddr1 = 5'd2; raddr2 = 5'd30;
    count_busy("soft", n);
    idle_inputs();
    n_cmp++;
    if (n !== 32) begin
      n_err++;
      $display("FAIL soft_len: busy edges %0d want 32", n);
    end
    check_all_zero("soft");
  endtask

  task automatic test_mid_clear_reset();
    int n;
    we0 = 1; waddr0 = 5'd6; wdata0 = 32'h66;
    tick();
    we0 = 0;
    clr = 1;
    tick();
    clr = 0;
    repeat (10) tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_busy: got %b want 1", busy);
    end
    rst = 1;
    tick();
    rst = 0;
    count_busy("mid", n);
    n_cmp++;
    if (n !== 32) begin
      n_err++;
      $display("FAIL mid_len: busy edges %0d want 32", n);
    end
    raddr1 = 5'd6; raddr2 = 5'd6;
    #1;
    n_cmp++;
    if (rdata1 !== 32'h0 || nb_rdata2 !== 32'h0) begin
      n_err++;
      $display("FAIL mid_reg6: got %h/%h want 0", rdata1, nb_rdata2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1;
    idle_inputs();
    raddr1 = '0; raddr2 = '0;
    test_reset();
    test_write_read();
    test_conflict();
    test_x0();
    test_dual_write();
    test_soft_clear();
    test_mid_clear_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/int_regfile_mp.md
INT_REGFILE_MP -- requirements
Module: int_regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: register data width in bits.
REQ-002 SHALL have parameter NREG, default 32: register count, a power of two, minimum 2.
REQ-003 SHALL have parameter ZERO_X0, default 1: when 1, register 0 reads 0 and ignores writes.
REQ-004 SHALL have parameter BYPASS, default 1: when 1, same-cycle write data is forwarded to the read ports.
REQ-005 SHALL have derived localparam AW = clog2(NREG), the address width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port clr, input, 1 bit: soft-clear request, sampled in IDLE only.
REQ-009 SHALL have port we0, input, 1 bit: write enable, write port 0.
REQ-010 SHALL have port waddr0, input, AW bits: write address, port 0.
REQ-011 SHALL have port wdata0, input, XLEN bits: write data, port 0.
REQ-012 SHALL have ports we1, waddr1 and wdata1, inputs of 1, AW and XLEN bits: write port 1.
REQ-013 SHALL have ports raddr1 and raddr2, inputs, AW bits each: read addresses.
REQ-014 SHALL have ports rdata1 and rdata2, outputs, XLEN bits each: combinational read data.
REQ-015 SHALL have port busy, output, 1 bit: high while the clear sequence runs.

Function
REQ-016 SHALL implement a two-state FSM with states IDLE and CLEAR, plus an AW-bit clear counter cnt.
REQ-017 SHALL make the CLEAR-state transitions at each edge:
  - write zero to register cnt and increment cnt;
  - when cnt == NREG-1, go to IDLE and set cnt to 0.
REQ-018 SHALL, in IDLE, go to CLEAR with cnt = 0 at an edge where clr = 1, and ignore writes at that edge.
REQ-019 SHALL ignore clr while in CLEAR; the sequence does not restart.
REQ-020 SHALL drive busy = 1 exactly while the state is CLEAR.
REQ-021 SHALL ignore we0 and we1 while busy, and drive rdata1 = rdata2 = 0 while busy.
REQ-022 SHALL, in IDLE, write wdata0 to waddr0 when we0 = 1 and wdata1 to waddr1 when we1 = 1, at the same edge.
REQ-023 SHALL let port 1 win when both ports write the same address at the same edge.
REQ-024 SHALL drop writes to address 0 when ZERO_X0 = 1, and return 0 for any read of address 0.
REQ-025 SHALL return stored contents for reads when BYPASS = 0; a write is visible from the cycle after its edge.
REQ-026 SHALL, when BYPASS = 1 and in IDLE, forward wdata1 on a read address matching an active waddr1, else wdata0 on a match with an active waddr0, else stored data.
REQ-027 SHALL never forward a suppressed address-0 write when ZERO_X0 = 1.
REQ-028 SHALL make both read ports independent; any address, including duplicates, is legal on both.

Reset
REQ-029 SHALL, at an edge with rst = 1, set state = CLEAR and cnt = 0, and ignore clr and writes.
REQ-030 SHALL set busy = 1 after reset; rdata1 and rdata2 read 0 until the clear completes.
REQ-031 SHALL, after rst deasserts, zero registers 0..NREG-1 over exactly NREG edges, then set busy = 0.
REQ-032 SHALL restart the sequence from cnt = 0 when rst is asserted mid-CLEAR.
REQ-033 SHALL not depend on simulation-only memory initialisation for any register contents.

Verification
REQ-034 Reset: rst high 2 cycles, then low -> busy = 1 for exactly 32 cycles; afterwards every raddr reads 0.
REQ-035 Write/read: we0 = 1, waddr0 = 5, wdata0 = 0xDEADBEEF -> raddr1 = 5 reads 0xDEADBEEF, same cycle if BYPASS = 1, next cycle if BYPASS = 0.
REQ-036 Conflict: we0 = we1 = 1, both addresses 7, wdata0 = 0x11, wdata1 = 0x22 -> register 7 = 0x22, and the bypass also returns 0x22.
REQ-037 x0: we1 = 1, waddr1 = 0, wdata1 = 0xFFFFFFFF -> rdata2 at raddr2 = 0 reads 0, both in the same cycle and afterwards.
REQ-038 Soft clear: fill registers 1..31 with their index, pulse clr, assert we0 during CLEAR -> busy for 32 cycles, all reads 0, no write lands.
REQ-039 Mid-clear reset: rst at cnt = 10 -> cnt restarts at 0; busy stays high for 32 more cycles after rst drops.
